hilo_muldiv_unit: RTL and testbench
===================================

# hilo_muldiv_unit

- Owns the architectural HI/LO register pair and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO as multi-cycle operations.
- Its HI_OUT/LO_OUT drive the ALU's HI_IN/LO_IN, closing the HI/LO loop. The ALU's MFHI/MFLO are reads of this block's state.
- Sits beside the ALU in the execute stage. The pipeline must stall on Busy_OUT before issuing MFHI/MFLO or a new HI/LO operation.

## Interface
- DATA_WIDTH, 32, operand and HI/LO width; only 32 is supported.
- CLOCK_IN  input  1  rising-edge clock.
- RESET_IN  input  1  synchronous, active-high reset.
- Start_IN  input  1  request; sampled only when Busy_OUT=0.
- Op_IN  input  3  operation, encoded per hilo_pkg.
- OperandA_IN  input  32  dividend / multiplicand / MTHI-MTLO source.
- OperandB_IN  input  32  divisor / multiplier.
- Busy_OUT  output  1  operation in flight.
- Done_OUT  output  1  one-cycle pulse: operation committed or rejected.
- DivZero_OUT  output  1  one-cycle pulse with Done_OUT when a DIV/DIVU has OperandB_IN=0.
- HI_OUT  output  32  architectural HI register.
- LO_OUT  output  32  architectural LO register.

## Operation
- Reset (any cycle, including mid-operation): go to IDLE and abort any in-flight work. All outputs reset to 0: HI_OUT, LO_OUT, Busy_OUT, Done_OUT, DivZero_OUT.
- States and transitions:
  - IDLE -> MUL when Start_IN with MULT/MULTU.
  - IDLE -> DIV when Start_IN with DIV/DIVU and B≠0.
  - MUL/DIV -> SIGN after 32 iterations.
  - SIGN -> IDLE.
- Single-edge operations (complete in IDLE):
  - MTHI/MTLO: write OperandA_IN into HI or LO at the start edge.
  - DIV/DIVU with B=0: HI/LO unchanged; Done_OUT and DivZero_OUT pulse.
- Start_IN is ignored while Busy_OUT=1. Start_IN with an undefined Op_IN is ignored, with no Done_OUT.
- Operand capture: operands are latched at the start edge and later input changes have no effect. For signed operations the latched values are converted to magnitudes, and the result sign flags are recorded:
  - product / quotient sign = A[31]^B[31];
  - remainder sign = A[31].
- MUL: radix-2 shift-add, one multiplier bit per cycle, with a 64-bit accumulator.
- DIV: restoring division, one quotient bit per cycle, with a 33-bit partial remainder.
- SIGN: two's-complement negation per the recorded flags, then commit.
  - Multiply: {HI,LO} = 64-bit product.
  - Divide: LO = quotient, HI = remainder.
- Arithmetic is modulo 2^32 per register. DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- HI/LO change only at commit edges, MTHI/MTLO edges and reset. They hold their prior values throughout an operation.

## Timing
- Define e0 as the edge that samples Start_IN.
- Multiply/divide (iterative):
  - Busy_OUT is high in the cycles after e0 through e33.
  - Iterations occur at e1..e32; commit is at e33.
  - After e33: Done_OUT=1 for one cycle, Busy_OUT=0, and the new HI/LO are visible.
  - A new Start_IN can be sampled at e34.
- MTHI/MTLO and divide-by-zero:
  - Busy_OUT is never asserted.
  - Done_OUT pulses in the cycle after e0.
  - Back-to-back starts are accepted every cycle.
- Done_OUT and Busy_OUT are never high in the same cycle.

## Configuration
- HILO_FAST_MULT_EN defined: MULT/MULTU use a single-cycle 64-bit multiply.
  - The product is registered at e0 and goes through SIGN, committing at e1.
  - Done_OUT pulses after e1; Busy_OUT is high for one cycle.
  - The MUL iteration state is not built.
- HILO_FAST_MULT_EN undefined: iterative 33-edge multiply as above.
- Divide is iterative in both builds.

## Structure
- hilo_pkg holds:
  - op encodings: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; values 6–7 are reserved;
  - the state enum (IDLE, MUL, DIV, SIGN);
  - ITER_COUNT=32.
- Sub-module hilo_divider holds the restoring-divide iteration datapath (partial remainder, quotient shift, step enable). Control and sign handling stay in the top module.

## Test plan
- MULT A=0xFFFFFFFF, B=2 -> after 33 edges, HI=0xFFFFFFFF, LO=0xFFFFFFFE, Done_OUT one cycle. MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=100, B=7 -> LO=14, HI=2. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU B=0 with HI=0x1234, LO=0x5678 preloaded via MTHI/MTLO -> Done_OUT and DivZero_OUT pulse after one edge, HI/LO unchanged, Busy_OUT stays 0.
- Start MULTU 3×5, then drive Start_IN=1 with DIVU at e5 and change the operands -> second request ignored; HI=0, LO=15 at commit; only one Done_OUT.
- Start DIV 50/5 and assert RESET_IN at e10 -> next cycle: HI=LO=0, Busy_OUT=0, no Done_OUT; a subsequent DIVU 9/4 gives LO=2, HI=1.
- Build with HILO_FAST_MULT_EN: MULT 0xFFFFFFFF×0xFFFFFFFF -> HI=0, LO=1 committed at e1; Done_OUT in the cycle after e1.

Source files
------------

// File: rtl/hilo_pkg.sv
// Shared op encodings, FSM states and iteration constants for the HI/LO multiply/divide unit.
package hilo_pkg;

  localparam int unsigned ITER_COUNT = 32;
  localparam int unsigned CNT_W      = 6;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_SIGN = 2'd3
  } state_e;

endpackage

// File: rtl/hilo_divider.sv
// Restoring unsigned divider datapath: one quotient bit per step, magnitudes only.
module hilo_divider #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic                  step_i,
  input  logic [DATA_WIDTH-1:0] dividend_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  output logic [DATA_WIDTH-1:0] quotient_o,
  output logic [DATA_WIDTH-1:0] remainder_o
);

  localparam int unsigned W = DATA_WIDTH;

  logic [W-1:0] rem_q, rem_d;
  logic [W-1:0] quo_q, quo_d;
  logic [W-1:0] dvs_q, dvs_d;
  logic [W:0]   part_c;
  logic [W:0]   trial_c;

  // The dividend shifts out of the quotient register MSB-first into the partial remainder.
  always_comb begin
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    part_c  = {rem_q, quo_q[W-1]};
    trial_c = part_c - {1'b0, dvs_q};
    if (load_i) begin
      rem_d = '0;
      quo_d = dividend_i;
      dvs_d = divisor_i;
    end else if (step_i) begin
      if (!trial_c[W]) begin
        rem_d = trial_c[W-1:0];
        quo_d = {quo_q[W-2:0], 1'b1};
      end else begin
        rem_d = part_c[W-1:0];
        quo_d = {quo_q[W-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
    end
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO register pair with iterative MULT/MULTU/DIV/DIVU and single-edge MTHI/MTLO.
// Define HILO_FAST_MULT_EN for a single-cycle multiplier in place of the shift-add loop.
module hilo_muldiv_unit
  import hilo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  CLOCK_IN,
  input  logic                  RESET_IN,
  input  logic                  Start_IN,
  input  logic [2:0]            Op_IN,
  input  logic [DATA_WIDTH-1:0] OperandA_IN,
  input  logic [DATA_WIDTH-1:0] OperandB_IN,
  output logic                  Busy_OUT,
  output logic                  Done_OUT,
  output logic                  DivZero_OUT,
  output logic [DATA_WIDTH-1:0] HI_OUT,
  output logic [DATA_WIDTH-1:0] LO_OUT
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned W2 = 2 * DATA_WIDTH;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic             neg_q, neg_d;
  logic             neg_rem_q, neg_rem_d;
  logic             is_div_q, is_div_d;
  logic [W-1:0]     hi_q, hi_d;
  logic [W-1:0]     lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             divz_q, divz_d;
`ifndef HILO_FAST_MULT_EN
  logic [W-1:0]     mcand_q, mcand_d;
  logic [W:0]       mul_sum_c;
`endif

  logic             signed_c;
  logic             last_iter_c;
  logic [W-1:0]     a_mag_c, b_mag_c;
  logic             div_load_c, div_step_c;
  logic [W-1:0]     div_quo_c, div_rem_c;

  hilo_divider #(.DATA_WIDTH(W)) u_divider (
    .clk_i       (CLOCK_IN),
    .rst_i       (RESET_IN),
    .load_i      (div_load_c),
    .step_i      (div_step_c),
    .dividend_i  (a_mag_c),
    .divisor_i   (b_mag_c),
    .quotient_o  (div_quo_c),
    .remainder_o (div_rem_c)
  );

  // Next-state and datapath control; signed ops run on magnitudes and fix the sign in SIGN.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    neg_d       = neg_q;
    neg_rem_d   = neg_rem_q;
    is_div_d    = is_div_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    done_d      = 1'b0;
    divz_d      = 1'b0;
    div_load_c  = 1'b0;
    div_step_c  = 1'b0;
`ifndef HILO_FAST_MULT_EN
    mcand_d     = mcand_q;
    mul_sum_c   = {1'b0, acc_q[W2-1:W]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
`endif
    signed_c    = (Op_IN == OP_MULT) || (Op_IN == OP_DIV);
    a_mag_c     = (signed_c && OperandA_IN[W-1]) ? -OperandA_IN : OperandA_IN;
    b_mag_c     = (signed_c && OperandB_IN[W-1]) ? -OperandB_IN : OperandB_IN;
    last_iter_c = (cnt_q == CNT_W'(ITER_COUNT - 1));

    case (state_q)
      ST_IDLE: begin
        if (Start_IN) begin
          case (Op_IN)
            OP_MULT, OP_MULTU: begin
              neg_d     = signed_c && (OperandA_IN[W-1] ^ OperandB_IN[W-1]);
              neg_rem_d = 1'b0;
              is_div_d  = 1'b0;
              cnt_d     = '0;
`ifdef HILO_FAST_MULT_EN
              acc_d     = W2'(a_mag_c) * W2'(b_mag_c);
              state_d   = ST_SIGN;
`else
              mcand_d   = a_mag_c;
              acc_d     = {{W{1'b0}}, b_mag_c};
              state_d   = ST_MUL;
`endif
            end
            OP_DIV, OP_DIVU: begin
              if (OperandB_IN == '0) begin
                done_d = 1'b1;
                divz_d = 1'b1;
              end else begin
                neg_d      = signed_c && (OperandA_IN[W-1] ^ OperandB_IN[W-1]);
                neg_rem_d  = signed_c && OperandA_IN[W-1];
                is_div_d   = 1'b1;
                cnt_d      = '0;
                div_load_c = 1'b1;
                state_d    = ST_DIV;
              end
            end
            OP_MTHI: begin
              hi_d   = OperandA_IN;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = OperandA_IN;
              done_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
`ifndef HILO_FAST_MULT_EN
      ST_MUL: begin
        acc_d = {mul_sum_c, acc_q[W-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (last_iter_c) state_d = ST_SIGN;
      end
`endif
      ST_DIV: begin
        div_step_c = 1'b1;
        cnt_d      = cnt_q + CNT_W'(1);
        if (last_iter_c) state_d = ST_SIGN;
      end
      ST_SIGN: begin
        if (is_div_q) begin
          lo_d = neg_q ? -div_quo_c : div_quo_c;
          hi_d = neg_rem_q ? -div_rem_c : div_rem_c;
        end else begin
          {hi_d, lo_d} = neg_q ? -acc_q : acc_q;
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLOCK_IN) begin
    if (RESET_IN) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      is_div_q  <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      divz_q    <= 1'b0;
`ifndef HILO_FAST_MULT_EN
      mcand_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      is_div_q  <= is_div_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      divz_q    <= divz_d;
`ifndef HILO_FAST_MULT_EN
      mcand_q   <= mcand_d;
`endif
    end
  end

  assign Busy_OUT    = busy_q;
  assign Done_OUT    = done_q;
  assign DivZero_OUT = divz_q;
  assign HI_OUT      = hi_q;
  assign LO_OUT      = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: directed cases plus randomized ops against an arithmetic model.
module tb_hilo_muldiv_unit;

`ifdef HILO_FAST_MULT_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] opa, opb;
  logic        busy, done, divz;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  hilo_muldiv_unit #(.DATA_WIDTH(32)) dut (
    .CLOCK_IN    (clk),
    .RESET_IN    (rst),
    .Start_IN    (start),
    .Op_IN       (op),
    .OperandA_IN (opa),
    .OperandB_IN (opb),
    .Busy_OUT    (busy),
    .Done_OUT    (done),
    .DivZero_OUT (divz),
    .HI_OUT      (hi),
    .LO_OUT      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Issue one op, wait for its Done pulse and compare against plain-arithmetic results.
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp_hi, exp_lo;
    logic [63:0] up;
    longint      sa, sb, p;
    bit          exp_dz;
    int          exp_lat;
    int          n;
    exp_hi  = m_hi;
    exp_lo  = m_lo;
    exp_dz  = 1'b0;
    exp_lat = 0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'd0: begin p = sa * sb; {exp_hi, exp_lo} = p; exp_lat = MUL_LAT; end
      3'd1: begin up = {32'b0, a} * {32'b0, b}; {exp_hi, exp_lo} = up; exp_lat = MUL_LAT; end
      3'd2: begin
        if (b == 0) exp_dz = 1'b1;
        else begin exp_lo = 32'(sa / sb); exp_hi = 32'(sa % sb); exp_lat = DIV_LAT; end
      end
      3'd3: begin
        if (b == 0) exp_dz = 1'b1;
        else begin exp_lo = a / b; exp_hi = a % b; exp_lat = DIV_LAT; end
      end
      3'd4: exp_hi = a;
      3'd5: exp_lo = a;
      default: ;
    endcase

    @(negedge clk);
    start = 1'b1; op = o; opa = a; opb = b;
    @(posedge clk); #1;
    start = 1'b0; opa = $urandom; opb = $urandom;
    check("busy_after_e0", 64'(busy), 64'(exp_lat > 0));
    n = 0;
    while (!done && n < 40) begin
      check("busy_done_excl", 64'(busy & done), 64'(0));
      if (n == 16) begin
        check("hi_hold", 64'(hi), 64'(m_hi));
        check("lo_hold", 64'(lo), 64'(m_lo));
      end
      @(posedge clk); #1;
      n++;
    end
    check("latency", 64'(n), 64'(exp_lat));
    check("done", 64'(done), 64'(1));
    check("divzero", 64'(divz), 64'(exp_dz));
    check("busy_at_done", 64'(busy), 64'(0));
    check("hi", 64'(hi), 64'(exp_hi));
    check("lo", 64'(lo), 64'(exp_lo));
    m_hi = exp_hi;
    m_lo = exp_lo;
    if (exp_lat > 0) begin
      @(posedge clk); #1;
      check("done_one_cycle", 64'(done), 64'(0));
    end
  endtask

  initial begin
    int dones, at;
    logic [31:0] hi_at, lo_at;
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    rst = 1'b1; start = 1'b0; op = '0; opa = '0; opb = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hi", 64'(hi), 64'(0));
    check("rst_lo", 64'(lo), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_divz", 64'(divz), 64'(0));
    @(negedge clk); rst = 1'b0;

    // Preload, then divide by zero must leave HI/LO alone.
    do_op(3'd4, 32'h0000_1234, 32'h0);
    do_op(3'd5, 32'h0000_5678, 32'h0);
    do_op(3'd3, 32'h0000_0063, 32'h0);
    do_op(3'd2, 32'h8000_0000, 32'h0);

    do_op(3'd0, 32'hFFFF_FFFF, 32'h2);
    do_op(3'd1, 32'hFFFF_FFFF, 32'h2);
    do_op(3'd2, 32'hFFFF_FFF9, 32'h2);
    do_op(3'd3, 32'd100,       32'd7);
    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op(3'd2, 32'd7,         32'hFFFF_FFFE);

    // A second start while busy is ignored and operand changes do not leak in.
    @(negedge clk);
    start = 1'b1; op = 3'd1; opa = 32'd3; opb = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0; at = 0; hi_at = '0; lo_at = '0;
    for (int n = 1; n <= 40; n++) begin
      if (n == 5) begin start = 1'b1; op = 3'd3; opa = 32'd77; opb = 32'd3; end
      @(posedge clk); #1;
      if (n == 5) begin start = 1'b0; opa = $urandom; opb = $urandom; end
      if (done) begin dones++; at = n; hi_at = hi; lo_at = lo; end
    end
    check("ovl_done_count", 64'(dones), 64'(1));
    check("ovl_done_edge", 64'(at), 64'(MUL_LAT));
    check("ovl_hi", 64'(hi_at), 64'(0));
    check("ovl_lo", 64'(lo_at), 64'(15));
    m_hi = 32'd0; m_lo = 32'd15;

    // Reset in the middle of a divide.
    do_op(3'd4, 32'hDEAD_BEEF, 32'h0);
    @(negedge clk);
    start = 1'b1; op = 3'd2; opa = 32'd50; opb = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("mrst_hi", 64'(hi), 64'(0));
    check("mrst_lo", 64'(lo), 64'(0));
    check("mrst_busy", 64'(busy), 64'(0));
    check("mrst_done", 64'(done), 64'(0));
    m_hi = '0; m_lo = '0;
    @(negedge clk); rst = 1'b0;
    do_op(3'd3, 32'd9, 32'd4);

    // Reserved op codes do nothing.
    for (int k = 6; k <= 7; k++) begin
      @(negedge clk);
      start = 1'b1; op = 3'(k); opa = 32'hAAAA_5555; opb = 32'h1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int n = 0; n < 3; n++) begin
        check("rsv_done", 64'(done), 64'(0));
        check("rsv_busy", 64'(busy), 64'(0));
        @(posedge clk); #1;
      end
      check("rsv_hi", 64'(hi), 64'(m_hi));
      check("rsv_lo", 64'(lo), 64'(m_lo));
    end

    // Randomized mix with occasional zero divisors and small operands.
    for (int t = 0; t < 40; t++) begin
      ro = 3'($urandom_range(0, 5));
      ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'h0;
        1:       rb = 32'($urandom_range(1, 9));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      do_op(ro, ra, rb);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
